// File: rtl/rpn_stack_engine.sv
`default_nettype none
// ============================================================================
//  Module   : rpn_stack_engine
//  Purpose  : Stack-and-ALU engine for the RPN calculator. Holds up to DEPTH
//             operands of DATA_W bits in a synchronous-read stack memory, keeps
//             the top of stack in a register, and executes PUSH, POP, DUP,
//             ADD, SUB, MUL and CLEAR through a valid/ready handshake.
//
//  Ports    : CLOCK_50   in   system clock, rising edge active
//             RESET_N    in   asynchronous active-low reset
//             cmd_valid  in   command present
//             cmd_op     in   opcode (0 PUSH,1 POP,2 ADD,3 SUB,4 MUL,5 DUP,
//                             6 CLEAR, 7 illegal)
//             cmd_data   in   PUSH operand
//             cmd_ready  out  engine idle, command may be accepted
//             done       out  one-cycle completion pulse (errors included)
//             tos        out  top-of-stack value, 0 when empty
//             depth      out  number of valid entries, 0..DEPTH
//             carry      out  flag from the last ADD/SUB/MUL
//             err        out  sticky error code (01 ovf, 10 unf, 11 illegal)
//
//  Revision : 1.0  initial release
// ============================================================================
module rpn_stack_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       cmd_valid,
    input  logic [2:0]                 cmd_op,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       cmd_ready,
    output logic                       done,
    output logic [DATA_W-1:0]          tos,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       carry,
    output logic [1:0]                 err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int DEPTH_W = AW + 1;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state;

    // Command latched at acceptance
    logic [2:0]           op_q;
    logic [DATA_W-1:0]    data_q;
    logic                 err_pend_q;
    logic [1:0]           err_code_q;

    // Stack storage and read path
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    rd_q;
    logic [DATA_W-1:0]    nos_q;

    // Combinational helpers
    logic                 accept;
    logic                 chk_err;
    logic [1:0]           chk_code;
    logic                 short_path;
    logic [AW-1:0]        push_addr;
    logic [AW-1:0]        nos_addr;
    logic [DATA_W:0]      sum;
    logic [DATA_W:0]      diff;
    logic [2*DATA_W-1:0]  prod;
    logic [DATA_W-1:0]    alu_res;
    logic                 alu_carry;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // The slot above the top is mem[depth]; the entry below the top is
    // mem[depth-2]. When depth is DEPTH the push address wraps, but that case
    // is always an overflow and never writes.
    assign push_addr = depth[AW-1:0];
    assign nos_addr  = depth[AW-1:0] - AW'(2);

    // Error classification is done at acceptance against the current depth,
    // so an erroring command never disturbs the stack.
    always_comb begin
        chk_err  = 1'b0;
        chk_code = ERR_NONE;
        case (cmd_op)
            OP_PUSH: begin
                if (depth == DEPTH_FULL) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_OVERFLOW;
                end
            end
            OP_DUP: begin
                if (depth == DEPTH_FULL) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_OVERFLOW;
                end else if (depth == '0) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_UNDERFLOW;
                end
            end
            OP_POP: begin
                if (depth == '0) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_UNDERFLOW;
                end
            end
            OP_ADD, OP_SUB, OP_MUL: begin
                if (depth < DEPTH_TWO) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_UNDERFLOW;
                end
            end
            OP_CLEAR: begin
                chk_err  = 1'b0;
                chk_code = ERR_NONE;
            end
            default: begin
                chk_err  = 1'b1;
                chk_code = ERR_ILLEGAL;
            end
        endcase
    end

    // Commands that never need the second-from-top operand skip the read.
    assign short_path = chk_err || (cmd_op == OP_PUSH) || (cmd_op == OP_DUP)
                     || (cmd_op == OP_CLEAR);

    // ALU on the captured NOS and the cached top of stack.
    assign sum  = {1'b0, nos_q} + {1'b0, tos};
    assign diff = {1'b0, nos_q} - {1'b0, tos};
    assign prod = {{DATA_W{1'b0}}, nos_q} * {{DATA_W{1'b0}}, tos};

    always_comb begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
        case (op_q)
            OP_SUB: begin
                alu_res   = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];           // borrow out
            end
            OP_MUL: begin
                alu_res   = prod[DATA_W-1:0];
                alu_carry = |prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
        endcase
    end

    // Stack memory: no reset, synchronous read. Writes happen only in WR, and
    // because state is reset asynchronously an aborted command never writes.
    always_ff @(posedge CLOCK_50) begin
        if (state == S_RD) begin
            rd_q <= mem[nos_addr];
        end
        if ((state == S_WR) && !err_pend_q) begin
            case (op_q)
                OP_PUSH:                mem[push_addr] <= data_q;
                OP_DUP:                 mem[push_addr] <= tos;
                OP_ADD, OP_SUB, OP_MUL: mem[nos_addr]  <= alu_res;
                default: ;
            endcase
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            tos        <= '0;
            depth      <= '0;
            carry      <= 1'b0;
            err        <= ERR_NONE;
            op_q       <= OP_PUSH;
            data_q     <= '0;
            err_pend_q <= 1'b0;
            err_code_q <= ERR_NONE;
            nos_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= cmd_op;
                        data_q     <= cmd_data;
                        err_pend_q <= chk_err;
                        err_code_q <= chk_code;
                        state      <= short_path ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    state <= S_RDW;
                end
                S_RDW: begin
                    nos_q <= rd_q;
                    state <= S_WR;
                end
                S_WR: begin
                    if (err_pend_q) begin
                        err <= err_code_q;
                    end else begin
                        case (op_q)
                            OP_PUSH: begin
                                tos   <= data_q;
                                depth <= depth + DEPTH_ONE;
                            end
                            OP_DUP: begin
                                depth <= depth + DEPTH_ONE;
                            end
                            OP_POP: begin
                                // Popping the last entry exposes an empty stack.
                                tos   <= (depth == DEPTH_ONE) ? '0 : nos_q;
                                depth <= depth - DEPTH_ONE;
                            end
                            OP_ADD, OP_SUB, OP_MUL: begin
                                tos   <= alu_res;
                                carry <= alu_carry;
                                depth <= depth - DEPTH_ONE;
                            end
                            OP_CLEAR: begin
                                tos   <= '0;
                                depth <= '0;
                                carry <= 1'b0;
                                err   <= ERR_NONE;
                            end
                            default: ;
                        endcase
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpn_stack_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rpn_stack_engine
//  Purpose  : Self-checking bench for rpn_stack_engine (DATA_W=8, DEPTH=16).
//             A table of commands with hand-computed tos/depth/carry/err and
//             done latency, plus hand-written reset and abort sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rpn_stack_engine;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           MUL = 3'd4, DUP = 3'd5, CLR = 3'd6, ILL = 3'd7;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [2:0]        cmd_op    = 3'd0;
    logic [DATA_W-1:0] cmd_data  = '0;
    logic              cmd_ready;
    logic              done;
    logic [DATA_W-1:0] tos;
    logic [4:0]        depth;
    logic              carry;
    logic [1:0]        err;

    rpn_stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .done      (done),
        .tos       (tos),
        .depth     (depth),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] tos;
        logic [4:0] depth;
        logic       carry;
        logic [1:0] err;
        int         lat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic [2:0] op, input int data, input int t,
                       input int d, input int c, input int e, input int lat);
        vec_t v;
        v.op = op; v.data = 8'(data); v.tos = 8'(t); v.depth = 5'(d);
        v.carry = 1'(c); v.err = 2'(e); v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one command and return the number of edges from acceptance to
    // the edge after which done is seen high (-1 if it never appears).
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                           output int lat);
        int guard;
        guard = 0;
        lat   = -1;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input int t, input int d,
                                 input int c, input int e);
        check({tag, ".tos"},   int'(tos),   t);
        check({tag, ".depth"}, int'(depth), d);
        check({tag, ".carry"}, int'(carry), c);
        check({tag, ".err"},   int'(err),   e);
    endtask

    initial begin
        int lat;

        // ---------------- vector table ----------------
        //   op    data  tos dep c err lat
        add(PUSH,    5,    5, 1, 0, 0, 2);
        add(PUSH,    3,    3, 2, 0, 0, 2);
        add(ADD,     0,    8, 1, 0, 0, 4);
        add(CLR,     0,    0, 0, 0, 0, 2);
        add(PUSH,  200,  200, 1, 0, 0, 2);
        add(PUSH,  100,  100, 2, 0, 0, 2);
        add(ADD,     0,   44, 1, 1, 0, 4);   // 300 mod 256, carry out
        add(PUSH,    3,    3, 2, 1, 0, 2);   // carry held by PUSH
        add(PUSH,    5,    5, 3, 1, 0, 2);
        add(SUB,     0,  254, 2, 1, 0, 4);   // 3-5 borrows
        add(PUSH,   16,   16, 3, 1, 0, 2);
        add(PUSH,   16,   16, 4, 1, 0, 2);
        add(MUL,     0,    0, 3, 1, 0, 4);   // 256 overflows the byte
        add(ADD,     0,  254, 2, 0, 0, 4);   // 254+0
        add(SUB,     0,   46, 1, 1, 0, 4);   // 44-254 = -210 -> 46
        add(PUSH,    9,    9, 2, 1, 0, 2);
        add(MUL,     0,  158, 1, 1, 0, 4);   // 46*9 = 414 -> 158
        add(CLR,     0,    0, 0, 0, 0, 2);
        // underflow / illegal from empty
        add(POP,     0,    0, 0, 0, 2, 2);
        add(PUSH,    7,    7, 1, 0, 2, 2);   // err sticky
        add(ADD,     0,    7, 1, 0, 2, 2);
        add(ILL,     0,    7, 1, 0, 3, 2);
        add(CLR,     0,    0, 0, 0, 0, 2);
        add(DUP,     0,    0, 0, 0, 2, 2);
        add(CLR,     0,    0, 0, 0, 0, 2);
        // dup / pop sequence
        add(PUSH,    9,    9, 1, 0, 0, 2);
        add(DUP,     0,    9, 2, 0, 0, 2);
        add(POP,     0,    9, 1, 0, 0, 4);
        add(POP,     0,    0, 0, 0, 0, 4);
        // fill to DEPTH, then overflow
        for (int i = 1; i <= DEPTH; i++) add(PUSH, i, i, i, 0, 0, 2);
        add(PUSH,   17,   16, 16, 0, 1, 2);
        add(DUP,     0,   16, 16, 0, 1, 2);
        add(POP,     0,   15, 15, 0, 1, 4);
        add(PUSH,   99,   99, 16, 0, 1, 2);  // write to the last slot
        add(ADD,     0,  114, 15, 0, 1, 4);  // 15+99
        add(CLR,     0,    0, 0, 0, 0, 2);

        // ---------------- reset state ----------------
        #12;
        check("rst.ready", int'(cmd_ready), 1);
        check("rst.done",  int'(done),      0);
        check_outputs("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[k]) begin
            run_cmd(vecs[k].op, vecs[k].data, lat);
            check($sformatf("v%0d.lat", k), lat, vecs[k].lat);
            check_outputs($sformatf("v%0d", k), int'(vecs[k].tos),
                          int'(vecs[k].depth), int'(vecs[k].carry),
                          int'(vecs[k].err));
        end

        // ---------------- done is a single-cycle pulse ----------------
        @(posedge clk);
        #1;
        check("done_pulse_width", int'(done), 0);

        // ---------------- reset during RDW of an ADD ----------------
        run_cmd(ILL, 8'd0, lat);                 // make err nonzero first
        run_cmd(PUSH, 8'd200, lat);
        run_cmd(PUSH, 8'd100, lat);
        check_outputs("pre_abort", 100, 2, 0, 3);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_data  = 8'd0;
        @(posedge clk);                          // E0: accepted, enters RD
        #1;
        cmd_valid = 1'b0;
        check("busy.ready", int'(cmd_ready), 0);
        @(posedge clk);                          // E1: enters RDW
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.ready", int'(cmd_ready), 1);
        check("abort.done",  int'(done),      0);
        check_outputs("abort", 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold.done", int'(done), 0);
        check_outputs("abort_hold", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(PUSH, 8'd1, lat);
        check("post_rst.lat", lat, 2);
        check_outputs("post_rst", 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog: the run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rpn_stack_engine.md
# rpn_stack_engine

Parametrised stack-and-ALU engine for the RPN calculator. It holds up to DEPTH operands of DATA_W bits in an internal synchronous-read stack memory and caches the top of stack in a register. It executes push, pop, dup, add, sub, mul and clear commands through a valid/ready handshake, and reports stack depth, an arithmetic carry flag and a sticky error code. It sits between the key/switch input decoder and the HEX/LEDR display logic.

## Interface
- DATA_W, 8: operand and result width in bits.
- DEPTH, 16: maximum number of stack entries; must be a power of two, at least 2.
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_op  input  3  opcode:
  - 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 CLEAR.
  - 7 is illegal.
- cmd_data  input  DATA_W  operand for PUSH; ignored by every other opcode.
- cmd_ready  output  1  high only in state IDLE.
- done  output  1  one-cycle pulse when a command completes, including error completions.
- tos  output  DATA_W  top-of-stack value; 0 when the stack is empty.
- depth  output  $clog2(DEPTH)+1  number of valid entries, 0 to DEPTH.
- carry  output  1  arithmetic flag from the last ADD, SUB or MUL.
- err  output  2  sticky error code:
  - 00 none, 01 overflow, 10 underflow, 11 illegal opcode.

## Operation
- The stack is stored in mem[0..DEPTH-1]. Entry depth-1 is the top and is mirrored in the tos register. The memory read has one cycle of latency.
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both high. cmd_op and cmd_data are latched at acceptance.
- States and transitions:
  - IDLE → WR for PUSH, DUP, CLEAR, and any error.
  - IDLE → RD for POP, ADD, SUB, MUL.
  - RD → RDW.
  - RDW → WR.
  - WR → DONE.
  - DONE → IDLE.
- RD drives the read address depth-2. In RDW the value NOS = mem[depth-2] is captured.
- PUSH: mem[depth] ← cmd_data; tos ← cmd_data; depth + 1.
- DUP: mem[depth] ← tos; depth + 1.
- POP: depth − 1; tos ← NOS, or tos ← 0 when the stack becomes empty.
- ADD, SUB and MUL combine NOS and tos, write the result to mem[depth-2] and tos, and reduce depth by 1.
  - ADD: result = NOS + tos; carry = bit DATA_W of the sum.
  - SUB: result = NOS − tos; carry = 1 on borrow (NOS < tos unsigned).
  - MUL: result = low DATA_W bits of the product; carry = 1 if any high bit is nonzero.
  - carry is unchanged by every other command.
- CLEAR: depth ← 0, tos ← 0, err ← 00, carry ← 0. Memory contents are not cleared.
- Errors leave the stack, tos and carry untouched, set err, and still take the WR→DONE path:
  - Overflow: PUSH or DUP with depth == DEPTH.
  - Underflow: POP or DUP with depth == 0, or ADD/SUB/MUL with depth < 2.
  - Illegal: opcode 7.
- err is sticky. A later error overwrites the code. Only CLEAR or reset returns err to 00.

## Timing
- Reset values while RESET_N is low: state IDLE, cmd_ready 1, done 0, tos 0, depth 0, carry 0, err 00. Memory contents are undefined.
- Reset is asynchronous. Asserting it in any state aborts the command in flight with no partial write. The first command can be accepted on the first rising edge after RESET_N is released.
- Latency from the accepting edge E0 to the done pulse:
  - PUSH, DUP, CLEAR and all errors: done is high between E2 and E3.
  - POP, ADD, SUB, MUL: done is high between E4 and E5.
- tos, depth, carry and err update on the edge that enters DONE and are stable while done is high.
- cmd_ready drops at E0 and rises again on the edge leaving DONE. Back-to-back commands therefore take 3 or 5 cycles each.
- cmd_valid while cmd_ready is low is ignored. The producer holds the command until it is accepted.
- Boundaries:
  - depth saturates at exactly DEPTH; overflow is flagged, with no wrap to 0.
  - A write to mem[DEPTH-1] is legal.
  - POP from depth 1 leaves tos = 0.

## Test plan
- Reset, then PUSH 5, PUSH 3, ADD (DATA_W=8) → tos=8, depth=1, carry=0, done 4 cycles after ADD acceptance.
- PUSH 200, PUSH 100, ADD → tos=44, carry=1. PUSH 3, PUSH 5, SUB → tos=254, carry=1. PUSH 16, PUSH 16, MUL → tos=0, carry=1.
- DEPTH=16: 16 PUSHes of values 1..16 → depth=16, tos=16. A 17th PUSH → err=01, depth=16, tos=16. CLEAR → err=00, depth=0, tos=0.
- From empty: POP → err=10, depth=0. PUSH 7, ADD → err=10, tos=7, depth=1. Opcode 7 → err=11, done after 2 cycles.
- PUSH 9, DUP, POP, POP → tos sequence 9, 9, 9, 0; depth 1, 2, 1, 0.
- Assert RESET_N low during the RDW state of an ADD with depth=2 → all outputs at reset values immediately. After release, PUSH 1 → tos=1, depth=1.
